// File: rtl/sobel_pkg.sv
// Shared widths, kernel weights and saturation helper for the streaming Sobel core.
package sobel_pkg;

  localparam int K_SIDE = 1;
  localparam int K_MID  = 2;

  function automatic int grad_w(input int data_w);
    return data_w + 3;
  endfunction

  function automatic int mag_w(input int data_w);
    return data_w + 4;
  endfunction

  function automatic logic [31:0] saturate(input logic [31:0] val, input int data_w);
    logic [31:0] max_v;
    max_v = (32'd1 << data_w) - 32'd1;
    return (val > max_v) ? max_v : val;
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Two-row line buffer: row1 is the previous line, row2 the line before it, both read one cycle after the write beat.
module sobel_line_buf #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 512,
  parameter int AW     = $clog2(IMG_W)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] row1,
  output logic [DATA_W-1:0] row2
);

  logic [DATA_W-1:0] mem0 [IMG_W];
  logic [DATA_W-1:0] mem1 [IMG_W];

  // Read-before-write: the old row moves down into mem1 as the new pixel lands in mem0.
  always_ff @(posedge clk) begin
    if (we) begin
      row1       <= mem0[addr];
      row2       <= mem1[addr];
      mem0[addr] <= din;
      mem1[addr] <= mem0[addr];
    end
  end

endmodule

// File: rtl/sobel_stream_core.sv
// Streaming 3x3 Sobel gradient-magnitude core, one pixel per valid beat, no backpressure.
// Define SOBEL_THRESH_EN to add thresh_in and binarise the magnitude.
module sobel_stream_core
  import sobel_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic              pixel_valid_in,
  input  logic              sof_in,
`ifdef SOBEL_THRESH_EN
  input  logic [DATA_W-1:0] thresh_in,
`endif
  output logic [DATA_W-1:0] pixel_out,
  output logic              pixel_valid_out,
  output logic              sol_out,
  output logic              eof_out,
  output logic              err_sof
);

  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int GRAD_W = grad_w(DATA_W);
  localparam int MAG_W  = mag_w(DATA_W);
  localparam int SUM_W  = DATA_W + 2;

  logic [CW-1:0] col, pos_col;
  logic [RW-1:0] row, pos_row;
  logic          last_col, last_row;

  always_comb begin
    pos_col  = sof_in ? '0 : col;
    pos_row  = sof_in ? '0 : row;
    last_col = (pos_col == CW'(IMG_W - 1));
    last_row = (pos_row == RW'(IMG_H - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      err_sof <= 1'b0;
    end else if (pixel_valid_in) begin
      if (sof_in && (col != '0 || row != '0)) err_sof <= 1'b1;
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : pos_row + RW'(1);
      end else begin
        col <= pos_col + CW'(1);
        row <= pos_row;
      end
    end
  end

  logic [DATA_W-1:0] lb_row1, lb_row2;

  sobel_line_buf #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_line_buf (
    .clk  (clk),
    .we   (pixel_valid_in),
    .addr (pos_col),
    .din  (pixel_in),
    .row1 (lb_row1),
    .row2 (lb_row2)
  );

  // Input capture aligned with the line-buffer read; the window shifts one cycle later.
  logic              s0_valid, s0_emit, s0_sol, s0_eof;
  logic [DATA_W-1:0] s0_pix;

  always_ff @(posedge clk) begin
    if (rst) s0_valid <= 1'b0;
    else     s0_valid <= pixel_valid_in;
    if (pixel_valid_in) begin
      s0_pix  <= pixel_in;
      s0_emit <= (pos_row >= RW'(2)) && (pos_col >= CW'(2));
      s0_sol  <= (pos_col == CW'(2));
      s0_eof  <= last_row && last_col;
    end
  end

  logic [DATA_W-1:0] win [3][3];
  logic              s1_valid, s1_sol, s1_eof;

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= s0_valid && s0_emit;
    if (s0_valid) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb_row2;
      win[1][2] <= lb_row1;
      win[2][2] <= s0_pix;
      s1_sol    <= s0_sol;
      s1_eof    <= s0_eof;
    end
  end

  function automatic logic [SUM_W-1:0] kern3(input logic [DATA_W-1:0] a, b, c);
    return SUM_W'(K_SIDE) * SUM_W'(a) + SUM_W'(K_MID) * SUM_W'(b) + SUM_W'(K_SIDE) * SUM_W'(c);
  endfunction

  logic signed [GRAD_W-1:0] s2_gx, s2_gy;
  logic                     s2_valid, s2_sol, s2_eof;

  always_ff @(posedge clk) begin
    if (rst) s2_valid <= 1'b0;
    else     s2_valid <= s1_valid;
    s2_gx  <= $signed(GRAD_W'(kern3(win[0][2], win[1][2], win[2][2])))
            - $signed(GRAD_W'(kern3(win[0][0], win[1][0], win[2][0])));
    s2_gy  <= $signed(GRAD_W'(kern3(win[2][0], win[2][1], win[2][2])))
            - $signed(GRAD_W'(kern3(win[0][0], win[0][1], win[0][2])));
    s2_sol <= s1_sol;
    s2_eof <= s1_eof;
  end

  logic [GRAD_W-1:0] abs_gx, abs_gy;
  logic [MAG_W-1:0]  mag;

  always_comb begin
    abs_gx = s2_gx[GRAD_W-1] ? GRAD_W'(-s2_gx) : GRAD_W'(s2_gx);
    abs_gy = s2_gy[GRAD_W-1] ? GRAD_W'(-s2_gy) : GRAD_W'(s2_gy);
    mag    = MAG_W'(abs_gx) + MAG_W'(abs_gy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_out       <= '0;
      pixel_valid_out <= 1'b0;
      sol_out         <= 1'b0;
      eof_out         <= 1'b0;
    end else begin
      pixel_valid_out <= s2_valid;
      sol_out         <= s2_valid && s2_sol;
      eof_out         <= s2_valid && s2_eof;
      if (s2_valid) begin
`ifdef SOBEL_THRESH_EN
        pixel_out <= (32'(mag) >= 32'(thresh_in)) ? '1 : '0;
`else
        pixel_out <= DATA_W'(saturate(32'(mag), DATA_W));
`endif
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream_core.sv
// Scoreboard bench for sobel_stream_core on an 8x8 frame; honours SOBEL_THRESH_EN.
module tb_sobel_stream_core;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] pixel_in;
  logic          pixel_valid_in;
  logic          sof_in;
  logic [DW-1:0] pixel_out;
  logic          pixel_valid_out, sol_out, eof_out, err_sof;
`ifdef SOBEL_THRESH_EN
  logic [DW-1:0] thresh_in;
`endif

  sobel_stream_core #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk             (clk),
    .rst             (rst),
    .pixel_in        (pixel_in),
    .pixel_valid_in  (pixel_valid_in),
    .sof_in          (sof_in),
`ifdef SOBEL_THRESH_EN
    .thresh_in       (thresh_in),
`endif
    .pixel_out       (pixel_out),
    .pixel_valid_out (pixel_valid_out),
    .sol_out         (sol_out),
    .eof_out         (eof_out),
    .err_sof         (err_sof)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  typedef struct {
    int due;
    int pix;
    bit sol;
    bit eof;
  } exp_t;

  exp_t sbq[$];
  int   total = 0, bad = 0;
  int   n_out = 0, n_sol = 0, n_eof = 0;
  int   img[H][W];
  int   m_col = 0, m_row = 0;
  int   thr = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sobel_ref(input int r, input int c);
    int gx, gy, m;
    gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
    m = iabs(gx) + iabs(gy);
`ifdef SOBEL_THRESH_EN
    return (m >= thr) ? 255 : 0;
`else
    return (m > 255) ? 255 : m;
`endif
  endfunction

  function automatic int pix_of(input int pat, input int r, input int c);
    case (pat)
      0:       return 100;
      1:       return (c < 4) ? 0 : 255;
      default: return 10 * c;
    endcase
  endfunction

  // Output visible at the negedge after acceptance edge + 3.
  task automatic drive(input int pix, input bit v, input bit sof);
    exp_t e;
    @(posedge clk);
    #1;
    pixel_in       = DW'(pix);
    pixel_valid_in = v;
    sof_in         = sof;
    if (v) begin
      if (sof) begin
        m_row = 0;
        m_col = 0;
      end
      img[m_row][m_col] = pix;
      if (m_row >= 2 && m_col >= 2) begin
        e.due = edge_cnt + 4;
        e.pix = sobel_ref(m_row - 1, m_col - 1);
        e.sol = (m_col == 2);
        e.eof = (m_row == H - 1) && (m_col == W - 1);
        sbq.push_back(e);
      end
      if (m_col == W - 1) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1'b0, 1'b0);
  endtask

  task automatic frame(input int pat, input bit gaps, input bit with_sof);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gaps) drive(0, 1'b0, 1'b0);
        drive(pix_of(pat, r, c), 1'b1, with_sof && r == 0 && c == 0);
      end
  endtask

  task automatic clear_counts();
    n_out = 0;
    n_sol = 0;
    n_eof = 0;
  endtask

  task automatic frame_counts(input string tag, input int frames);
    idle(6);
    chk({tag, "_n_out"}, n_out, 36 * frames);
    chk({tag, "_n_sol"}, n_sol, 6 * frames);
    chk({tag, "_n_eof"}, n_eof, frames);
    clear_counts();
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clk);
    #1;
    rst            = 1'b1;
    pixel_valid_in = 1'b0;
    sof_in         = 1'b0;
    repeat (cycles) @(posedge clk);
    sbq.delete();
    m_row = 0;
    m_col = 0;
    #1;
    chk("rst_pixel_out", pixel_out, 0);
    chk("rst_valid", pixel_valid_out, 0);
    chk("rst_sol", sol_out, 0);
    chk("rst_eof", eof_out, 0);
    chk("rst_err_sof", err_sof, 0);
    rst = 1'b0;
    clear_counts();
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due == edge_cnt) begin
      chk("out_valid", pixel_valid_out, 1);
      chk("out_pixel", pixel_out, sbq[0].pix);
      chk("out_sol", sol_out, sbq[0].sol);
      chk("out_eof", eof_out, sbq[0].eof);
      void'(sbq.pop_front());
    end else if (pixel_valid_out) begin
      chk("unexpected_valid", pixel_valid_out, 0);
    end
    if (pixel_valid_out) begin
      n_out++;
      if (sol_out) n_sol++;
      if (eof_out) n_eof++;
    end
  end

  initial begin
    rst            = 1'b1;
    pixel_in       = '0;
    pixel_valid_in = 1'b0;
    sof_in         = 1'b0;
`ifdef SOBEL_THRESH_EN
    thresh_in      = '0;
`endif
    apply_reset(2);

    frame(0, 1'b0, 1'b1);
    frame_counts("flat", 1);
    chk("flat_err_sof", err_sof, 0);

    frame(1, 1'b0, 1'b1);
    frame_counts("step", 1);

    frame(2, 1'b0, 1'b1);
    frame_counts("ramp", 1);

    frame(2, 1'b1, 1'b1);
    frame_counts("ramp_gaps", 1);

`ifdef SOBEL_THRESH_EN
    thr = 80;
    thresh_in = 8'd80;
    frame(2, 1'b0, 1'b1);
    frame_counts("thr80", 1);
    thr = 81;
    thresh_in = 8'd81;
    frame(2, 1'b0, 1'b1);
    frame_counts("thr81", 1);
    thr = 0;
    thresh_in = 8'd0;
`endif

    // Back-to-back frames: row 0 input overlaps the previous frame's tail outputs.
    frame(2, 1'b0, 1'b1);
    frame(1, 1'b0, 1'b0);
    frame_counts("b2b", 2);

    for (int i = 0; i < 20; i++) drive(pix_of(2, i / W, i % W), 1'b1, i == 0);
    idle(6);
    chk("pre_resync_err_sof", err_sof, 0);
    clear_counts();
    frame(1, 1'b0, 1'b1);
    chk("resync_err_sof", err_sof, 1);
    frame_counts("resync", 1);
    frame(0, 1'b0, 1'b0);
    frame_counts("post_resync", 1);
    chk("err_sof_sticky", err_sof, 1);

    for (int i = 0; i < 30; i++) drive(pix_of(1, i / W, i % W), 1'b1, i == 0);
    apply_reset(1);
    idle(5);
    frame(2, 1'b0, 1'b0);
    frame_counts("after_rst", 1);

    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
